// File: rtl/fetch_if_id_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID register.
//   fetch_state_e    : fetch FSM states
//   NOP_INSTR        : instruction word written into IF/ID on a bubble
//   DEFAULT_RESET_PC : default PC after reset
//   pc_plus4()       : sequential successor of a PC, wraps modulo 2^32
package pipeline_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,   // no request outstanding
      WAIT    = 2'd1,   // request outstanding
      HOLD    = 2'd2,   // response buffered while stalled
      DISCARD = 2'd3    // outstanding response must be dropped
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_if_id_stage_if.sv
// Instruction-memory request/response bus.
//   imem_req    : request strobe, one cycle per request
//   imem_addr   : request address
//   imem_rvalid : response valid
//   imem_rdata  : instruction word
// master = fetch stage, slave = instruction memory.
interface fetch_if_id_stage_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_if_id_stage_if_id_register.sv
// IF/ID pipeline register.
//   clock, reset_n       : clock, asynchronous active-low reset
//   load_i               : capture pc_plus4_i / instr_i as a valid entry
//   hold_i               : keep current contents
//   flush_i              : write a bubble; beats load and hold
//   valid_o, pc_plus4_o, instr_o : registered contents
// With none of load/hold/flush asserted a bubble is written.
module if_id_register
   import pipeline_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        load_i,
   input  logic        hold_i,
   input  logic        flush_i,
   input  logic [31:0] pc_plus4_i,
   input  logic [31:0] instr_i,
   output logic        valid_o,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] instr_o
);

   logic        valid_q, valid_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic [31:0] instr_q, instr_d;

   always_comb begin
      valid_d    = 1'b0;
      pc_plus4_d = 32'h0;
      instr_d    = NOP_INSTR;
      if (flush_i) begin
         valid_d    = 1'b0;
      end else if (load_i) begin
         valid_d    = 1'b1;
         pc_plus4_d = pc_plus4_i;
         instr_d    = instr_i;
      end else if (hold_i) begin
         valid_d    = valid_q;
         pc_plus4_d = pc_plus4_q;
         instr_d    = instr_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q    <= 1'b0;
         pc_plus4_q <= 32'h0;
         instr_q    <= NOP_INSTR;
      end else begin
         valid_q    <= valid_d;
         pc_plus4_q <= pc_plus4_d;
         instr_q    <= instr_d;
      end
   end

   assign valid_o    = valid_q;
   assign pc_plus4_o = pc_plus4_q;
   assign instr_o    = instr_q;

endmodule

// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, keeps
// at most one instruction-memory request outstanding and drives IF/ID.
//   clock, reset_n             : clock, asynchronous active-low reset
//   ctrl_hazard_pc_write       : 1 = PC may advance
//   ctrl_hazard_if_id_write    : 1 = IF/ID may be written
//   redirect_valid/redirect_pc : taken branch/jump resolved in ID
//   imem                       : instruction-memory bus (master side)
//   if_id_valid/_pc_plus4/_instruction : IF/ID contents
//   bubble_count               : saturating count of bubbles into IF/ID
module fetch_if_id_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          CNT_W    = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 ctrl_hazard_pc_write,
   input  logic                 ctrl_hazard_if_id_write,
   input  logic                 redirect_valid,
   input  logic [31:0]          redirect_pc,
   fetch_if_id_stage_if.master  imem,
   output logic                 if_id_valid,
   output logic [31:0]          if_id_pc_plus4,
   output logic [31:0]          if_id_instruction,
   output logic [CNT_W-1:0]     bubble_count
);

   fetch_state_e     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      buf_q, buf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             data_avail;
   logic             accept;
   logic             bubble_wr;
   logic [31:0]      load_instr;

   // An rvalid seen in FETCH or HOLD is a protocol error and is ignored.
   assign data_avail = ((state_q == WAIT) && imem.imem_rvalid) || (state_q == HOLD);
   assign accept     = data_avail && ctrl_hazard_pc_write && ctrl_hazard_if_id_write
                       && !redirect_valid;
   assign load_instr = (state_q == HOLD) ? buf_q : imem.imem_rdata;

   // Same condition under which if_id_register writes a bubble.
   assign bubble_wr  = redirect_valid || (!accept && ctrl_hazard_if_id_write);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         buf_q   <= NOP_INSTR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      buf_d   = buf_q;
      case (state_q)
         FETCH: begin
            if (redirect_valid) pc_d = redirect_pc;
            else                state_d = WAIT;
         end
         WAIT: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               // Without the response in hand it is still in flight and must be drained.
               state_d = imem.imem_rvalid ? FETCH : DISCARD;
            end else if (accept) begin
               // Back-to-back: the next request goes out this cycle, so stay in WAIT.
               pc_d = pc_plus4(pc_q);
            end else if (imem.imem_rvalid) begin
               buf_d   = imem.imem_rdata;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = FETCH;
            end else if (accept) begin
               pc_d    = pc_plus4(pc_q);
               state_d = FETCH;
            end
         end
         DISCARD: begin
            if (redirect_valid)    pc_d    = redirect_pc;
            if (imem.imem_rvalid)  state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      imem.imem_req  = 1'b0;
      imem.imem_addr = pc_q;
      case (state_q)
         FETCH: imem.imem_req = !redirect_valid;
         WAIT: begin
            if (accept) begin
               imem.imem_req  = 1'b1;
               imem.imem_addr = pc_plus4(pc_q);
            end
         end
         default: imem.imem_req = 1'b0;
      endcase
   end

   // Only bubbles that displace a real instruction, or come from a flush, are counted.
   always_comb begin
      cnt_d = cnt_q;
      if (bubble_wr && (if_id_valid || redirect_valid) && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign bubble_count = cnt_q;

   if_id_register u_if_id (
      .clock      (clock),
      .reset_n    (reset_n),
      .load_i     (accept),
      .hold_i     (!ctrl_hazard_if_id_write),
      .flush_i    (redirect_valid),
      .pc_plus4_i (pc_plus4(pc_q)),
      .instr_i    (load_instr),
      .valid_o    (if_id_valid),
      .pc_plus4_o (if_id_pc_plus4),
      .instr_o    (if_id_instruction)
   );

endmodule

// File: tb/tb_fetch_if_id_stage.sv
module tb_fetch_if_id_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        pcw, ifw, redir;
   logic [31:0] redir_pc;
   logic        valid;
   logic [31:0] pc4, instr;
   logic [15:0] bcnt;

   fetch_if_id_stage_if imem_bus ();

   fetch_if_id_stage #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
      .clock                   (clock),
      .reset_n                 (reset_n),
      .ctrl_hazard_pc_write    (pcw),
      .ctrl_hazard_if_id_write (ifw),
      .redirect_valid          (redir),
      .redirect_pc             (redir_pc),
      .imem                    (imem_bus),
      .if_id_valid             (valid),
      .if_id_pc_plus4          (pc4),
      .if_id_instruction       (instr),
      .bubble_count            (bcnt)
   );

   always #5 clock = ~clock;

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory contents: a fixed scramble of the address; word 0 reads 0x8C01_0004.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h8C01_0004;
   endfunction

   // ---------------- memory model ----------------
   bit          pend;
   int          cnt;
   logic [31:0] pend_addr;
   bit          rv_now;
   int          lat_min, lat_max;

   task automatic mem_sample();
      if (rv_now) pend = 1'b0;
      if (imem_bus.imem_req) begin
         chk("one_outstanding", 32'(pend), 32'd0);
         pend      = 1'b1;
         pend_addr = imem_bus.imem_addr;
         cnt       = int'($urandom_range(lat_max, lat_min));
      end
   endtask

   // ---------------- expected fetch stream ----------------
   // Delivered instructions are the sequential stream from the last redirect target.
   logic [31:0] expq[$];
   logic [31:0] seq_pc;
   bit          last_redir;
   logic [31:0] last_tgt;

   task automatic step(input logic p, input logic w, input logic r, input logic [31:0] t);
      @(posedge clock);
      #1;
      if (last_redir) begin
         expq.delete();
         seq_pc = last_tgt;
      end
      while (expq.size() < 4) begin
         expq.push_back(seq_pc);
         seq_pc = seq_pc + 32'd4;
      end
      rv_now = 1'b0;
      if (pend) begin
         cnt--;
         if (cnt == 0) rv_now = 1'b1;
      end
      imem_bus.imem_rvalid = rv_now;
      imem_bus.imem_rdata  = rv_now ? memf(pend_addr) : $urandom;
      pcw        = p;
      ifw        = w;
      redir      = r;
      redir_pc   = t;
      last_redir = r;
      last_tgt   = t;
      @(negedge clock);
      mem_sample();
   endtask

   task automatic wait_req(input string name, input logic [31:0] exp_addr);
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0);
         if (imem_bus.imem_req) break;
      end
      if (!imem_bus.imem_req) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: no imem_req within 10 cycles, expected addr %08h", name, exp_addr);
      end else begin
         chk(name, imem_bus.imem_addr, exp_addr);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit          mon_en = 1'b0;
   logic        m_valid, m_redir, m_ifw;
   logic [31:0] m_pc4, m_instr;
   logic [15:0] exp_cnt;
   logic [31:0] mon_a, mon_e4;

   always @(negedge clock) begin
      if (mon_en) begin
         if (m_redir) begin
            chk("flush_valid", 32'(valid), 32'd0);
         end else if (!m_ifw) begin
            chk("stall_hold_valid", 32'(valid), 32'(m_valid));
            chk("stall_hold_pc4", pc4, m_pc4);
            chk("stall_hold_instr", instr, m_instr);
         end
         if (!valid) begin
            chk("bubble_pc4_zero", pc4, 32'h0);
            chk("bubble_instr_nop", instr, 32'h0);
         end
         if (valid && (!m_valid || pc4 != m_pc4)) begin
            if (expq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL load_unexpected: got pc4 %08h with nothing expected", pc4);
            end else begin
               mon_a  = expq.pop_front();
               mon_e4 = mon_a + 32'd4;
               chk("load_pc4", pc4, mon_e4);
               chk("load_instr", instr, memf(mon_a));
            end
         end
         if ((m_redir || (m_valid && !valid)) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         chk("bubble_count", 32'(bcnt), 32'(exp_cnt));
         m_valid = valid;
         m_pc4   = pc4;
         m_instr = instr;
         m_redir = redir;
         m_ifw   = ifw;
      end
   end

   // ---------------- stimulus ----------------
   logic [31:0] stall_pc, stall_next;

   initial begin
      reset_n = 1'b1;
      pcw = 1'b1; ifw = 1'b1; redir = 1'b0; redir_pc = 32'h0;
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = 32'h0;
      pend = 1'b0; rv_now = 1'b0; cnt = 0; pend_addr = 32'h0;
      lat_min = 1; lat_max = 1;
      last_redir = 1'b0; last_tgt = 32'h0; seq_pc = RST_PC;
      m_valid = 1'b0; m_redir = 1'b0; m_ifw = 1'b1; m_pc4 = 32'h0; m_instr = 32'h0;
      exp_cnt = 16'h0;
      #1 reset_n = 1'b0;
      #11;
      chk("rst_req", 32'(imem_bus.imem_req), 32'd1);
      chk("rst_addr", imem_bus.imem_addr, RST_PC);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_pc4", pc4, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_bcnt", 32'(bcnt), 32'd0);

      @(negedge clock);
      #2 reset_n = 1'b1;
      while (expq.size() < 4) begin
         expq.push_back(seq_pc);
         seq_pc = seq_pc + 32'd4;
      end
      chk("first_req", 32'(imem_bus.imem_req), 32'd1);
      chk("first_addr", imem_bus.imem_addr, RST_PC);
      mem_sample();
      mon_en = 1'b1;

      // 1-cycle memory: second request at 4, IF/ID valid 2 edges after release
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("second_addr", imem_bus.imem_addr, 32'h4);
      chk("second_req", 32'(imem_bus.imem_req), 32'd1);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("first_valid", 32'(valid), 32'd1);
      chk("first_pc4", pc4, 32'h4);
      chk("first_instr", instr, 32'h8C01_0004);
      repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

      // load-use stall while a response arrives
      step(1'b0, 1'b0, 1'b0, 32'h0);
      stall_pc = imem_bus.imem_addr;
      chk("stall_no_req1", 32'(imem_bus.imem_req), 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("stall_no_req2", 32'(imem_bus.imem_req), 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("stall_release_no_req", 32'(imem_bus.imem_req), 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      stall_next = stall_pc + 32'd4;
      chk("stall_buf_valid", 32'(valid), 32'd1);
      chk("stall_buf_pc4", pc4, stall_next);
      chk("stall_next_req", 32'(imem_bus.imem_req), 32'd1);
      chk("stall_next_addr", imem_bus.imem_addr, stall_next);
      repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);

      // taken branch with a response in the same cycle
      step(1'b1, 1'b1, 1'b1, 32'h40);
      chk("branch_rvalid_present", 32'(rv_now), 32'd1);
      chk("branch_no_req", 32'(imem_bus.imem_req), 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("branch_bubble", 32'(valid), 32'd0);
      chk("branch_req", 32'(imem_bus.imem_req), 32'd1);
      chk("branch_addr", imem_bus.imem_addr, 32'h40);
      repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

      // redirect while a 3-cycle request is outstanding
      lat_min = 3; lat_max = 3;
      step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'h80);
      chk("discard_no_rvalid", 32'(rv_now), 32'd0);
      chk("discard_no_req", 32'(imem_bus.imem_req), 32'd0);
      wait_req("discard_next_addr", 32'h80);
      lat_min = 1; lat_max = 1;
      repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);

      // redirect coincident with a full stall: flush wins
      step(1'b0, 1'b0, 1'b1, 32'h200);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("flush_over_stall_valid", 32'(valid), 32'd0);
      chk("flush_over_stall_instr", instr, 32'h0);
      repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

      // PC wrap
      step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
      wait_req("wrap_addr", 32'hFFFF_FFFC);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("wrap_next_addr", imem_bus.imem_addr, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("wrap_valid", 32'(valid), 32'd1);
      chk("wrap_pc4", pc4, 32'h0);
      chk("wrap_instr", instr, memf(32'hFFFF_FFFC));
      repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);

      // randomized traffic
      lat_min = 1; lat_max = 3;
      for (int n = 0; n < 3000; n++) begin
         step(logic'($urandom_range(0, 7) != 0),
              logic'($urandom_range(0, 7) != 0),
              logic'($urandom_range(0, 15) == 0),
              32'($urandom_range(0, 1023)) << 2);
      end

      // saturation: one counted bubble per edge
      lat_min = 1; lat_max = 1;
      for (int n = 0; n < 65600; n++) step(1'b1, 1'b1, 1'b1, 32'h100);
      chk("bcnt_saturated", 32'(bcnt), 32'h0000_FFFF);
      step(1'b1, 1'b1, 1'b1, 32'h100);
      chk("bcnt_stays_saturated", 32'(bcnt), 32'h0000_FFFF);

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
